core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
Multi-cycle control FSM for the 9-bit core. It owns the program counter, latches each fetched instruction and walks it through fetch/execute/memory/writeback. It emits one-cycle register-write strobes and runs a req/ack handshake to data memory. It sits between the instruction ROM, the per-instruction control decoder, the register file and data memory, and reports program completion.

Parameters:
PC_W, 10, program counter width; instruction ROM depth is 2^PC_W
HALT_INSTR, 9'h1FF, instruction encoding that ends the program
CNT_W, 16, width of retired-instruction counter
TIMEOUT, 64, memory-ack watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin execution from PC 0 (level, sampled in IDLE/HALT)
instr  input  9  instruction ROM data at address pc (combinational read)
branch_taken  input  1  ALU branch-condition result, valid in EXEC
branch_target  input  PC_W  resolved branch target, valid in EXEC
mem_ack  input  1  data memory completes the current access
pc  output  PC_W  instruction ROM address
ir  output  9  latched instruction to the control decoder
ir_en  output  1  IR load strobe (FETCH)
reg_we  output  1  register-file write strobe, one cycle
mem_req  output  1  data memory request, held until ack
mem_we  output  1  1 = store, 0 = load; valid while mem_req
done  output  1  program halted
retired  output  CNT_W  retired instruction count, saturating
err  output  1  memory timeout flag (0 without the optional feature)

Behaviour:
- Reset (async, active-high): state=IDLE, pc=0, ir=0, retired=0; all strobes, done and err are 0.
- States: IDLE, FETCH, EXEC, MEM, WB, HALT.
- IDLE: start=1 -> FETCH with pc=0 and retired=0.
- FETCH: ir_en=1, ir<=instr. Next state is EXEC, or HALT if instr==HALT_INSTR.
- EXEC: class decoded from ir[8:7].
  - 00 (ALU) and 10 (immediate): reg_we=1, pc<=pc+1 -> FETCH.
  - 01 (branch): pc<=branch_taken ? branch_target : pc+1 -> FETCH. No register write.
  - 11 (memory): -> MEM. mem_we=ir[6].
- MEM: mem_req=1 and mem_we stay constant until mem_ack.
  - If mem_ack and store: pc+1 -> FETCH.
  - If mem_ack and load: -> WB.
  - mem_ack arriving in any other state is ignored.
  - mem_ack is also accepted in the first MEM cycle, giving a minimum 1-cycle access.
- WB: reg_we=1, pc+1 -> FETCH.
- Latency per instruction: ALU/imm/branch = 2 cycles; store = 2+N; load = 3+N, where N is the number of MEM cycles up to and including ack.
- retired increments on every transition back to FETCH from EXEC/MEM/WB. It saturates at 2^CNT_W-1 and does not wrap.
- pc+1 wraps from 2^PC_W-1 to 0. A branch to its own address is legal (infinite loop); no detection.
- HALT: done=1 and pc is held. start=1 restarts: pc=0, retired=0, done->0, state FETCH.
- start is ignored outside IDLE/HALT.
- Reset asserted mid-MEM drops mem_req immediately (asynchronously). No access is retried.

Optional Feature:
CORE_SEQ_MEM_TIMEOUT_EN:
- When defined: a counter runs in MEM. If TIMEOUT cycles pass with no mem_ack, mem_req drops, err=1 and the state goes to HALT (done=1). err stays high until reset or restart via start.
- When undefined: no counter is built, err is tied to 0, and MEM waits indefinitely.

Decomposition:
- Package core_pkg:
  - state enum seq_state_t (IDLE, FETCH, EXEC, MEM, WB, HALT)
  - instruction class enum instr_class_t (ALU=2'b00, BRANCH=2'b01, IMM=2'b10, MEMORY=2'b11)
  - HALT_INSTR default constant
  - opcode field positions [8:7] and [6]
- One sub-module, pc_unit: PC register with async reset, load (branch/restart) and increment. Load has priority over increment.

Test Plan:
- Reset with start=1 held, then release reset -> FETCH on the next edge with pc=0 and retired=0 (checks retired is cleared when FETCH is entered from IDLE); outputs are 0 during reset.
- ROM {9'h000 ALU, 9'h100 IMM, 9'h1FF} -> reg_we pulses in cycles 2 and 4; done=1 with pc=2 and retired=2.
- Branch at pc=3 with branch_taken=1 and target=10 -> pc=10 after EXEC. Repeat with branch_taken=0 -> pc=4; no reg_we in either case.
- Load 9'h180 with mem_ack delayed 3 cycles -> mem_req high 3 cycles with mem_we=0, then reg_we in WB. Store 9'h1C0 with immediate ack -> mem_we=1 for 1 cycle, no reg_we.
- Assert reset during MEM -> mem_req=0 that same cycle and state=IDLE. With the macro defined, withhold ack for 64 cycles -> err=1, done=1.
- Jump to pc=1023 and execute ALU -> pc wraps to 0. Force retired to its maximum value -> it holds at 65535.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared state/class encodings and opcode field positions for core_sequencer
package core_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB, HALT} seq_state_t;
  typedef enum logic [1:0] {ALU = 2'b00, BRANCH = 2'b01, IMM = 2'b10, MEMORY = 2'b11} instr_class_t;
  localparam logic [8:0] HALT_INSTR_DEF = 9'h1FF;
  localparam int CLASS_HI = 8;
  localparam int CLASS_LO = 7;
  localparam int WE_BIT = 6;
  function automatic instr_class_t instr_class(input logic [8:0] i);
    return instr_class_t'(i[CLASS_HI:CLASS_LO]);
  endfunction
endpackage

// File: rtl/core_sequencer_pc_unit.sv
// pc_unit: program counter register; ports clk, reset (async high), load/load_val (priority), inc, pc
module pc_unit #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);
  logic [PC_W-1:0] pc_d, pc_q;
  always_comb pc_d = load ? load_val : inc ? pc_q + PC_W'(1) : pc_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) pc_q <= '0;
    else pc_q <= pc_d;
  assign pc = pc_q;
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/exec/mem/wb FSM; ports: clk, reset, start, instr, branch_taken/target, mem_ack -> pc, ir, ir_en, reg_we, mem_req, mem_we, done, retired, err; CORE_SEQ_MEM_TIMEOUT_EN adds the memory-ack watchdog
module core_sequencer
  import core_pkg::*;
#(
  parameter int         PC_W       = 10,
  parameter logic [8:0] HALT_INSTR = HALT_INSTR_DEF,
  parameter int         CNT_W      = 16,
  parameter int         TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       instr,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             mem_ack,
  output logic [PC_W-1:0]  pc,
  output logic [8:0]       ir,
  output logic             ir_en,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             done,
  output logic [CNT_W-1:0] retired,
  output logic             err
);
  seq_state_t state_q, state_d;
  instr_class_t cls;
  logic [8:0] ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic err_q, err_d;
  logic pc_load, pc_inc, retire, restart, timeout;
  logic [PC_W-1:0] pc_load_val;
  assign cls = instr_class(ir_q);
`ifdef CORE_SEQ_MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  always_comb begin
    tmo_d = (state_q == MEM && !mem_ack) ? tmo_q + TW'(1) : '0;
    timeout = state_q == MEM && !mem_ack && tmo_q == TW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    err_d = err_q;
    retire = 1'b0;
    restart = 1'b0;
    pc_load = 1'b0;
    pc_inc = 1'b0;
    unique case (state_q)
      IDLE, HALT: if (start) begin
        state_d = FETCH;
        restart = 1'b1;
        pc_load = 1'b1;
        err_d = 1'b0;
      end
      FETCH: begin
        ir_d = instr;
        state_d = instr == HALT_INSTR ? HALT : EXEC;
      end
      EXEC: if (cls == MEMORY) state_d = MEM;
      else begin
        state_d = FETCH;
        retire = 1'b1;
        pc_load = cls == BRANCH && branch_taken;
        pc_inc = !pc_load;
      end
      MEM: if (mem_ack) begin
        state_d = ir_q[WE_BIT] ? FETCH : WB;
        retire = ir_q[WE_BIT];
        pc_inc = ir_q[WE_BIT];
      end else if (timeout) begin
        state_d = HALT;
        err_d = 1'b1;
      end
      WB: begin
        state_d = FETCH;
        retire = 1'b1;
        pc_inc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    pc_load_val = restart ? '0 : branch_target;
    retired_d = restart ? '0 : (retire && !(&retired_q)) ? retired_q + CNT_W'(1) : retired_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ir_q <= '0;
      retired_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      retired_q <= retired_d;
      err_q <= err_d;
    end
  pc_unit #(.PC_W(PC_W)) u_pc (
    .clk(clk), .reset(reset), .load(pc_load), .inc(pc_inc), .load_val(pc_load_val), .pc(pc)
  );
  assign ir = ir_q;
  assign ir_en = state_q == FETCH;
  assign reg_we = (state_q == EXEC && (cls == ALU || cls == IMM)) || state_q == WB;
  assign mem_req = state_q == MEM;
  assign mem_we = mem_req && ir_q[WE_BIT];
  assign done = state_q == HALT;
  assign retired = retired_q;
  assign err = err_q;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed and random instruction-level checks of core_sequencer
module tb_core_sequencer;
  logic clk = 1'b0, reset, start, branch_taken, mem_ack, sat_rst;
  logic [9:0] branch_target, pc, sat_pc;
  logic [8:0] instr, ir, sat_ir;
  logic ir_en, reg_we, mem_req, mem_we, done, err;
  logic sat_ir_en, sat_reg_we, sat_mem_req, sat_mem_we, sat_done, sat_err;
  logic [15:0] retired;
  logic [3:0] sat_retired;
  logic [8:0] rom [1024];
  int errors = 0, checks = 0;
  int mpc, mret, dir_tgt, dir_ld_n, dir_st_n;
  bit rand_mode, dir_bt;

  always #5 clk = ~clk;
  assign instr = rom[pc];

  core_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem_ack(mem_ack), .pc(pc), .ir(ir), .ir_en(ir_en),
    .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .done(done), .retired(retired), .err(err)
  );

  core_sequencer #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(sat_rst), .start(1'b1), .instr(9'h000), .branch_taken(1'b0),
    .branch_target(10'd0), .mem_ack(1'b0), .pc(sat_pc), .ir(sat_ir), .ir_en(sat_ir_en),
    .reg_we(sat_reg_we), .mem_req(sat_mem_req), .mem_we(sat_mem_we), .done(sat_done),
    .retired(sat_retired), .err(sat_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    start = 1'b1;
    step();
    start = 1'b0;
    mpc = 0;
    mret = 0;
    chk("restart_pc", pc, 0);
    chk("restart_ret", retired, 0);
    chk("restart_done", done, 0);
  endtask

  // Instruction-level reference: one iteration per instruction, expected pc/retired carried in mpc/mret
  task automatic run(input int max_n);
    for (int k = 0; k < max_n; k++) begin
      logic [8:0] op;
      int n;
      chk("fetch_en", ir_en, 1);
      chk("fetch_pc", pc, mpc);
      chk("fetch_ret", retired, mret);
      op = rom[mpc];
      if (rand_mode) start = 1'($urandom);
      if (op == 9'h1FF) begin
        step();
        start = 1'b0;
        chk("halt_done", done, 1);
        chk("halt_pc", pc, mpc);
        chk("halt_ret", retired, mret);
        return;
      end
      branch_taken = rand_mode ? 1'($urandom) : dir_bt;
      branch_target = rand_mode ? 10'($urandom) : 10'(dir_tgt);
      step();
      chk("exec_ir", ir, op);
      chk("exec_we", reg_we, (op[8:7] == 2'b00 || op[8:7] == 2'b10) ? 1 : 0);
      chk("exec_req", mem_req, 0);
      if (op[8:7] != 2'b11) begin
        mpc = (op[8:7] == 2'b01 && branch_taken) ? int'(branch_target) : (mpc + 1) % 1024;
        step();
      end else begin
        n = rand_mode ? int'($urandom_range(1, 4)) : (op[6] ? dir_st_n : dir_ld_n);
        step();
        for (int i = 1; i <= n; i++) begin
          chk("mem_req", mem_req, 1);
          chk("mem_we", mem_we, op[6]);
          chk("mem_regwe", reg_we, 0);
          mem_ack = (i == n);
          step();
          mem_ack = 1'b0;
        end
        if (!op[6]) begin
          chk("wb_we", reg_we, 1);
          chk("wb_req", mem_req, 0);
          step();
        end
        mpc = (mpc + 1) % 1024;
      end
      mret = mret < 65535 ? mret + 1 : mret;
    end
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    reset = 1'b1; sat_rst = 1'b1; start = 1'b1; mem_ack = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    rand_mode = 0; dir_bt = 0; dir_tgt = 0; dir_ld_n = 1; dir_st_n = 1;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h1FF;
    rom[0] = 9'h000; rom[1] = 9'h100; rom[2] = 9'h1FF;
    step();
    step();
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_strobes", {ir_en, reg_we, mem_req, mem_we, done, err}, 0);
    chk("rst_ret", retired, 0);
    reset = 1'b0;
    step();
    start = 1'b0;
    chk("first_fetch", ir_en, 1);
    chk("first_pc", pc, 0);
    chk("first_ret", retired, 0);
    mpc = 0; mret = 0;
    run(10);
    chk("prog1_pc", pc, 2);
    chk("prog1_ret", retired, 2);

    rom[0] = 9'h000; rom[1] = 9'h000; rom[2] = 9'h000; rom[3] = 9'h080;
    dir_bt = 1; dir_tgt = 10;
    restart();
    run(10);
    chk("br_taken_pc", pc, 10);
    chk("br_taken_ret", retired, 4);
    dir_bt = 0;
    restart();
    run(10);
    chk("br_not_pc", pc, 4);
    chk("br_not_done", done, 1);

    rom[0] = 9'h180; rom[1] = 9'h1C0; rom[2] = 9'h1FF;
    dir_ld_n = 3; dir_st_n = 1;
    restart();
    run(10);
    chk("ldst_pc", pc, 2);
    chk("ldst_ret", retired, 2);

    rom[0] = 9'h080; rom[1023] = 9'h000;
    dir_bt = 1; dir_tgt = 1023;
    restart();
    run(2);
    chk("wrap_pc", pc, 0);
    chk("wrap_ret", retired, 2);

    rom[0] = 9'h180;
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("mem_before_rst", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("async_req", mem_req, 0);
    chk("async_idle", {ir_en, done, reg_we}, 0);
    chk("async_pc", pc, 0);
    step();
    reset = 1'b0;

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    cnt = 0;
    while (mem_req && cnt < 200) begin
      cnt++;
      step();
    end
`ifdef CORE_SEQ_MEM_TIMEOUT_EN
    chk("tmo_cycles", cnt, 64);
    chk("tmo_err", err, 1);
    chk("tmo_done", done, 1);
    restart();
    chk("tmo_err_clr", err, 0);
`else
    chk("wait_cycles", cnt, 200);
    chk("wait_err", err, 0);
    chk("wait_done", done, 0);
`endif

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 510));
    rand_mode = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    mpc = 0; mret = 0;
    run(300);

    sat_rst = 1'b0;
    step();
    for (int c = 0; c < 48; c++) begin
      if (c % 4 == 0) chk("sat_ret", sat_retired, (c / 2) < 15 ? c / 2 : 15);
      step();
    end
    chk("sat_hold", sat_retired, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
